morse_rx_ctrl: RTL

//  Timing front-end and sequencer for the Morse receive path. Samples a keyed line, measures mark and gap

---
 rtl/morse_rx_ctrl.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/morse_rx_ctrl.sv
// Morse receive front-end: synchronises the keyed line, times marks/gaps in dot units,
// assembles {len,pattern} codes, decodes them through the ROM and hands characters out via valid/ready.

module morse_code_receive_rom (
  input  logic [7:0] code,
  output logic [7:0] ascii
);
  // code = {len[2:0], pattern[4:0]}; first symbol is the MSB of the used bits, dash = 1.
  always_comb begin
    ascii = 8'h00;
    case (code)
      8'h20: ascii = 8'h45; // E
      8'h21: ascii = 8'h54; // T
      8'h40: ascii = 8'h49; // I
      8'h41: ascii = 8'h41; // A
      8'h42: ascii = 8'h4E; // N
      8'h43: ascii = 8'h4D; // M
      8'h60: ascii = 8'h53; // S
      8'h61: ascii = 8'h55; // U
      8'h62: ascii = 8'h52; // R
      8'h63: ascii = 8'h57; // W
      8'h64: ascii = 8'h44; // D
      8'h65: ascii = 8'h4B; // K
      8'h66: ascii = 8'h47; // G
      8'h67: ascii = 8'h4F; // O
      8'h80: ascii = 8'h48; // H
      8'h81: ascii = 8'h56; // V
      8'h82: ascii = 8'h46; // F
      8'h84: ascii = 8'h4C; // L
      8'h86: ascii = 8'h50; // P
      8'h87: ascii = 8'h4A; // J
      8'h88: ascii = 8'h42; // B
      8'h89: ascii = 8'h58; // X
      8'h8A: ascii = 8'h43; // C
      8'h8B: ascii = 8'h59; // Y
      8'h8C: ascii = 8'h5A; // Z
      8'h8D: ascii = 8'h51; // Q
      8'hA0: ascii = 8'h35; // 5
      8'hA1: ascii = 8'h34; // 4
      8'hA3: ascii = 8'h33; // 3
      8'hA7: ascii = 8'h32; // 2
      8'hAF: ascii = 8'h31; // 1
      8'hB0: ascii = 8'h36; // 6
      8'hB8: ascii = 8'h37; // 7
      8'hBC: ascii = 8'h38; // 8
      8'hBE: ascii = 8'h39; // 9
      8'hBF: ascii = 8'h30; // 0
      default: ascii = 8'h00;
    endcase
  end
endmodule

module morse_rx_ctrl #(
  parameter int UNIT_CYCLES = 100,
  parameter int DASH_UNITS  = 2,
  parameter int CHAR_UNITS  = 2,
  parameter int WORD_UNITS  = 5,
  parameter int ETX_UNITS   = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       err_pulse,
  output logic       overrun_pulse,
  output logic       busy
);
  localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYCLES - 1);
  localparam logic [4:0] DASH_U = 5'(DASH_UNITS);
  localparam logic [4:0] CHAR_U = 5'(CHAR_UNITS);
  localparam logic [4:0] WORD_U = 5'(WORD_UNITS);
  localparam logic [4:0] ETX_U  = 5'(ETX_UNITS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MARK = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]    sync;
  logic          key_s, key_q, rise, fall, edge_s;
  logic [CW-1:0] cyc, cyc_eff;
  logic [4:0]    units, units_eff, units_nxt;
  logic          run, wrap, tick;

  logic [1:0] state, state_n;
  logic [2:0] len, len_n;
  logic [4:0] pattern, pattern_n;
  logic       ovf, ovf_n, char_sent, char_sent_n;
  logic       emit, err_set, sym;
  logic [7:0] emit_val, rom_ascii;

  assign key_s  = sync[1];
  assign rise   = key_s & ~key_q;
  assign fall   = ~key_s & key_q;
  assign edge_s = rise | fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b00;
      key_q <= 1'b0;
    end else begin
      sync  <= {sync[0], key_in};
      key_q <= key_s;
    end
  end

  // The edge cycle itself is cycle 0 of the new interval, so a mark of N*UNIT_CYCLES
  // cycles reads units == N on the cycle its falling edge is seen.
  assign cyc_eff   = edge_s ? '0 : cyc;
  assign units_eff = edge_s ? 5'd0 : units;
  assign units_nxt = (units_eff == 5'd31) ? 5'd31 : units_eff + 5'd1;
  assign run       = (state != S_IDLE) | edge_s;
  assign wrap      = (cyc_eff == CYC_LAST);
  assign tick      = run & wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc   <= '0;
      units <= 5'd0;
    end else if (run) begin
      cyc   <= wrap ? '0 : cyc_eff + CW'(1);
      units <= wrap ? units_nxt : units_eff;
    end
  end

  morse_code_receive_rom u_rom (
    .code  ({len, pattern}),
    .ascii (rom_ascii)
  );

  assign sym = (units >= DASH_U);

  always_comb begin
    state_n     = state;
    len_n       = len;
    pattern_n   = pattern;
    ovf_n       = ovf;
    char_sent_n = char_sent;
    emit        = 1'b0;
    emit_val    = 8'h00;
    err_set     = 1'b0;
    case (state)
      S_IDLE: begin
        if (rise) begin
          state_n     = S_MARK;
          len_n       = 3'd0;
          pattern_n   = 5'd0;
          ovf_n       = 1'b0;
          char_sent_n = 1'b0;
        end
      end
      S_MARK: begin
        if (fall) begin
          state_n = S_GAP;
          if (len < 3'd5) begin
            pattern_n = {pattern[3:0], sym};
            len_n     = len + 3'd1;
          end else begin
            ovf_n = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (rise) begin
          state_n = S_MARK;
          if (units >= CHAR_U) begin
            len_n     = 3'd0;
            pattern_n = 5'd0;
            ovf_n     = 1'b0;
          end
        end else if (tick) begin
          // Thresholds are distinct, so at most one event fires per tick.
          if (units_nxt == CHAR_U && len != 3'd0) begin
            if (ovf || rom_ascii == 8'h00) begin
              err_set = 1'b1;
            end else begin
              emit        = 1'b1;
              emit_val    = rom_ascii;
              char_sent_n = 1'b1;
            end
            len_n     = 3'd0;
            pattern_n = 5'd0;
            ovf_n     = 1'b0;
          end else if (units_nxt == WORD_U && char_sent) begin
            emit        = 1'b1;
            emit_val    = 8'h20;
            char_sent_n = 1'b0;
          end else if (units_nxt == ETX_U) begin
            emit     = 1'b1;
            emit_val = 8'h03;
            state_n  = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      len       <= 3'd0;
      pattern   <= 5'd0;
      ovf       <= 1'b0;
      char_sent <= 1'b0;
    end else begin
      state     <= state_n;
      len       <= len_n;
      pattern   <= pattern_n;
      ovf       <= ovf_n;
      char_sent <= char_sent_n;
    end
  end

  // Holding register: a new emit may overwrite only a slot that is empty or being drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out      <= 8'h00;
      data_valid    <= 1'b0;
      err_pulse     <= 1'b0;
      overrun_pulse <= 1'b0;
    end else begin
      err_pulse     <= err_set;
      overrun_pulse <= emit & data_valid & ~data_ready;
      if (emit && (!data_valid || data_ready)) begin
        data_out   <= emit_val;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule
